// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared command encodings, FSM state and requester-owner types
//               for the instruction/data memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Downstream and data-port command encoding; codes 3..7 behave as NONE.
    localparam logic [2:0] CMD_NONE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    // True only for commands that start a memory transaction.
    function automatic logic is_active_cmd(input logic [2:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin picker, purely combinational.
//               A lone request is granted directly; on a tie the requester
//               that was not granted last wins.
// Ports       : req[0]=inst, req[1]=data   (in)
//               last_grant                 (in)  owner granted most recently
//               grant[1:0]                 (out) one-hot or zero
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_grant == OWN_DATA) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one single-ported memory between the instruction-fetch
//               port and the data port. One transaction in flight at a time;
//               contention resolved round-robin; read data routed back to
//               the requester that issued it.
// Ports       : clk, reset                    clock / sync active-high reset
//               inst_start/ready/addr         fetch request handshake
//               inst_data/inst_valid          fetch response (1-cycle pulse)
//               d_cmd/d_cmd_ready/d_addr/
//               d_wdata/d_wmask               data request handshake
//               d_rdata/d_rdata_valid         data read response
//               mem_cmd/mem_cmd_ready/mem_addr/
//               mem_wdata/mem_wmask           downstream command handshake
//               mem_rdata/mem_rdata_valid     downstream read return
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_start,
    output logic              inst_ready,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_data,
    output logic              inst_valid,
    input  logic [2:0]        d_cmd,
    output logic              d_cmd_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [DATA_W-1:0] d_wmask,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_rdata_valid,
    output logic [2:0]        mem_cmd,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_wmask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rdata_valid
);

    state_t     r_state;
    owner_t     r_owner;
    owner_t     r_last_grant;
    logic [1:0] w_req;
    logic [1:0] w_grant;
    logic       w_idle;

    assign w_req  = {is_active_cmd(d_cmd), inst_start};
    assign w_idle = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Grant is only meaningful while idle; any busy state blocks both ports.
    assign inst_ready  = w_idle & w_grant[0];
    assign d_cmd_ready = w_idle & w_grant[1];

    // The mem_* outputs double as the request latches: loaded on acceptance
    // and held untouched until the memory takes the command.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_owner       <= OWN_INST;
            r_last_grant  <= OWN_DATA;
            mem_cmd       <= CMD_NONE;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            inst_data     <= '0;
            inst_valid    <= 1'b0;
            d_rdata       <= '0;
            d_rdata_valid <= 1'b0;
        end else begin
            inst_valid    <= 1'b0;
            d_rdata_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant[0]) begin
                        mem_cmd      <= CMD_READ;
                        mem_addr     <= inst_addr;
                        mem_wdata    <= '0;
                        mem_wmask    <= '0;
                        r_owner      <= OWN_INST;
                        r_last_grant <= OWN_INST;
                        r_state      <= ISSUE;
                    end else if (w_grant[1]) begin
                        mem_cmd      <= d_cmd;
                        mem_addr     <= d_addr;
                        mem_wdata    <= d_wdata;
                        mem_wmask    <= d_wmask;
                        r_owner      <= OWN_DATA;
                        r_last_grant <= OWN_DATA;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_cmd_ready) begin
                        mem_cmd <= CMD_NONE;
                        // A write is complete once the memory accepts it.
                        r_state <= (mem_cmd == CMD_READ) ? RD_WAIT : IDLE;
                    end
                end
                RD_WAIT: begin
                    if (mem_rdata_valid) begin
                        if (r_owner == OWN_INST) begin
                            inst_data  <= mem_rdata;
                            inst_valid <= 1'b1;
                        end else begin
                            d_rdata       <= mem_rdata;
                            d_rdata_valid <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter. Requester tasks push
//               expected downstream commands and expected read responses
//               into queues on acceptance; a memory model and a response
//               monitor pop and compare them independently.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk;
    logic        reset;
    logic        inst_start;
    logic        inst_ready;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        inst_valid;
    logic [2:0]  d_cmd;
    logic        d_cmd_ready;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_wmask;
    logic [31:0] d_rdata;
    logic        d_rdata_valid;
    logic [2:0]  mem_cmd;
    logic        mem_cmd_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_rdata_valid;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_start      (inst_start),
        .inst_ready      (inst_ready),
        .inst_addr       (inst_addr),
        .inst_data       (inst_data),
        .inst_valid      (inst_valid),
        .d_cmd           (d_cmd),
        .d_cmd_ready     (d_cmd_ready),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_wmask         (d_wmask),
        .d_rdata         (d_rdata),
        .d_rdata_valid   (d_rdata_valid),
        .mem_cmd         (mem_cmd),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wmask       (mem_wmask),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid)
    );

    typedef struct {
        int          port;      // 0 inst, 1 data
        logic [31:0] data;
        int          exp_cyc;   // -1 when latency is not checked
    } rsp_t;

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] wmask;
        int          delay;     // cycles memory stalls before mem_cmd_ready
    } mcmd_t;

    rsp_t        rsp_q[$];
    mcmd_t       cmd_q[$];
    int          grant_q[$];
    int          hold_q[$];
    logic [31:0] mem_arr [logic [31:0]];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int n_inst_v = 0;
    int n_d_v    = 0;
    int rd_delay = 1;
    bit spur     = 1'b0;
    int hold     = 0;
    int rd_cnt   = 0;
    logic [31:0] rd_data = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        #2;
        mem_cmd_ready   = 1'b0;
        mem_rdata_valid = 1'b0;
        if (rd_cnt > 0) begin
            rd_cnt--;
            if (rd_cnt == 0) begin
                mem_rdata_valid = 1'b1;
                mem_rdata       = rd_data;
            end
        end
        if (spur) begin
            mem_rdata_valid = 1'b1;
            mem_rdata       = 32'h0000_0055;
        end
        if (reset === 1'b1) begin
            hold = 0;
        end else if (mem_cmd !== CMD_NONE) begin
            if (cmd_q.size() == 0) begin
                fail_now("mem_cmd_unexpected");
            end else begin
                hold++;
                chk("mem_cmd", {29'd0, mem_cmd}, {29'd0, cmd_q[0].cmd});
                chk("mem_addr", mem_addr, cmd_q[0].addr);
                if (cmd_q[0].cmd == CMD_WRITE) begin
                    chk("mem_wdata", mem_wdata, cmd_q[0].wdata);
                    chk("mem_wmask", mem_wmask, cmd_q[0].wmask);
                end
                if (hold > cmd_q[0].delay) begin
                    mem_cmd_ready = 1'b1;
                    hold_q.push_back(hold);
                    if (mem_cmd == CMD_READ) begin
                        rd_cnt  = rd_delay;
                        rd_data = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'hBAD0_BAD0;
                    end
                    hold = 0;
                    cmd_q.delete(0);
                end
            end
        end
    end

    // ---------------- response monitor ----------------
    task automatic check_rsp(input int port, input logic [31:0] data);
        rsp_t e;
        if (rsp_q.size() == 0) begin
            fail_now($sformatf("unexpected_valid port=%0d data=0x%08h", port, data));
        end else begin
            e = rsp_q.pop_front();
            chk("rsp_port", port, e.port);
            chk("rsp_data", data, e.data);
            if (e.exp_cyc >= 0) chk("rsp_latency_cycle", cyc, e.exp_cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (inst_valid === 1'b1) begin
                n_inst_v++;
                check_rsp(0, inst_data);
            end
            if (d_rdata_valid === 1'b1) begin
                n_d_v++;
                check_rsp(1, d_rdata);
            end
        end
    end

    // ---------------- requesters ----------------
    task automatic do_inst(input logic [31:0] addr, input logic [31:0] exp,
                           input bit track_lat, input bit expect_rsp, output int acc);
        mcmd_t c;
        rsp_t  r;
        inst_start = 1'b1;
        inst_addr  = addr;
        acc        = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (inst_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            fail_now("inst_accept_timeout");
        end else begin
            c.cmd = CMD_READ; c.addr = addr; c.wdata = '0; c.wmask = '0; c.delay = 0;
            cmd_q.push_back(c);
            if (expect_rsp) begin
                r.port = 0; r.data = exp; r.exp_cyc = track_lat ? acc + 3 : -1;
                rsp_q.push_back(r);
            end
            grant_q.push_back(0);
        end
        @(posedge clk);
        #1;
        inst_start = 1'b0;
    endtask

    task automatic do_data(input logic [2:0] cmd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] wmask,
                           input logic [31:0] exp, input int delay, output int acc);
        mcmd_t c;
        rsp_t  r;
        d_cmd   = cmd;
        d_addr  = addr;
        d_wdata = wdata;
        d_wmask = wmask;
        acc     = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (d_cmd_ready === 1'b1) begin
                acc = cyc;
                break;
            end
        end
        if (acc < 0) begin
            fail_now("data_accept_timeout");
        end else begin
            c.cmd = cmd; c.addr = addr; c.wdata = wdata; c.wmask = wmask; c.delay = delay;
            cmd_q.push_back(c);
            if (cmd == CMD_READ) begin
                r.port = 1; r.data = exp; r.exp_cyc = -1;
                rsp_q.push_back(r);
            end
            grant_q.push_back(1);
        end
        @(posedge clk);
        #1;
        d_cmd = CMD_NONE;
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rsp_q.size() == 0 && cmd_q.size() == 0 && rd_cnt == 0) break;
        end
        if (i == 60) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        rsp_q.delete();
        cmd_q.delete();
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int          acc_a, acc_b, acc_c, acc_d;
        int          sv_inst_v, sv_d_v;
        logic [31:0] sv_inst_data, sv_d_rdata;
        int          exp_grants[4];

        reset = 1'b1;
        inst_start = 1'b0; inst_addr = '0;
        d_cmd = CMD_NONE; d_addr = '0; d_wdata = '0; d_wmask = '0;
        mem_cmd_ready = 1'b0; mem_rdata = '0; mem_rdata_valid = 1'b0;

        mem_arr[32'h0000_0100] = 32'h0000_0013;
        mem_arr[32'h0000_0104] = 32'h1111_2222;
        mem_arr[32'h0000_0108] = 32'h00A0_0093;
        mem_arr[32'h0000_0300] = 32'hCAFE_F00D;
        mem_arr[32'h0000_0304] = 32'h0BAD_F00D;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_inst_ready", {31'd0, inst_ready}, 32'd0);
        chk("rst_d_cmd_ready", {31'd0, d_cmd_ready}, 32'd0);
        chk("rst_mem_cmd", {29'd0, mem_cmd}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", mem_wmask, 32'd0);
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_d_rdata_valid", {31'd0, d_rdata_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Fetch with zero-wait memory; back-to-back fetch shows ready at N+3.
        rd_delay = 1;
        hold_q.delete();
        do_inst(32'h100, 32'h0000_0013, 1'b1, 1'b1, acc_a);
        do_inst(32'h104, 32'h1111_2222, 1'b0, 1'b1, acc_b);
        chk("fetch_ready_again_cycle", acc_b, acc_a + 3);
        wait_drain();
        chk("fetch_cmd_hold_cycles", (hold_q.size() > 0) ? hold_q[0] : 0, 32'd1);
        chk("fetch_valid_count", n_inst_v, 32'd2);

        // Write stalled 3 cycles, then a data read right behind it.
        hold_q.delete();
        sv_d_v = n_d_v;
        do_data(CMD_WRITE, 32'h200, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0, 3, acc_a);
        do_data(CMD_READ, 32'h300, 32'h0, 32'h0, 32'hCAFE_F00D, 0, acc_b);
        chk("write_then_read_accept_cycle", acc_b, acc_a + 5);
        wait_drain();
        chk("write_cmd_hold_cycles", (hold_q.size() > 0) ? hold_q[0] : 0, 32'd4);
        chk("write_no_valid", n_d_v - sv_d_v, 32'd1);

        // Continuous contention from reset: inst, data, inst, data.
        do_reset(2);
        grant_q.delete();
        fork
            begin
                do_inst(32'h108, 32'h00A0_0093, 1'b0, 1'b1, acc_a);
                do_inst(32'h104, 32'h1111_2222, 1'b0, 1'b1, acc_b);
            end
            begin
                do_data(CMD_READ, 32'h304, 32'h0, 32'h0, 32'h0BAD_F00D, 0, acc_c);
                do_data(CMD_READ, 32'h300, 32'h0, 32'h0, 32'hCAFE_F00D, 0, acc_d);
            end
        join
        wait_drain();
        exp_grants[0] = 0; exp_grants[1] = 1; exp_grants[2] = 0; exp_grants[3] = 1;
        chk("grant_count", grant_q.size(), 32'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("grant_order[%0d]", i), (grant_q.size() > i) ? grant_q[i] : -1, exp_grants[i]);

        // Spurious read return while idle must be ignored.
        sv_inst_v = n_inst_v; sv_d_v = n_d_v;
        sv_inst_data = inst_data; sv_d_rdata = d_rdata;
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_inst_valid_count", n_inst_v - sv_inst_v, 32'd0);
        chk("spur_d_valid_count", n_d_v - sv_d_v, 32'd0);
        chk("spur_inst_data_held", inst_data, sv_inst_data);
        chk("spur_d_rdata_held", d_rdata, sv_d_rdata);
        @(posedge clk);
        #1;

        // Reset while waiting for read data; the late return is dropped.
        rd_delay = 2;
        sv_inst_v = n_inst_v;
        do_inst(32'h100, 32'h0, 1'b0, 1'b0, acc_a);
        @(posedge clk);
        #1;
        do_reset(1);
        repeat (3) @(negedge clk);
        chk("rst_rdwait_no_valid", n_inst_v - sv_inst_v, 32'd0);
        chk("rst_rdwait_inst_data", inst_data, 32'd0);
        @(posedge clk);
        #1;
        rd_delay = 1;
        do_inst(32'h108, 32'h00A0_0093, 1'b1, 1'b1, acc_a);
        wait_drain();
        chk("post_reset_fetch_count", n_inst_v - sv_inst_v, 32'd1);

        // Reserved data command code is not a request.
        d_cmd = 3'd5;
        d_addr = 32'h400;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("cmd5_d_cmd_ready", {31'd0, d_cmd_ready}, 32'd0);
            chk("cmd5_mem_cmd", {29'd0, mem_cmd}, 32'd0);
        end
        @(posedge clk);
        #1;
        d_cmd = CMD_NONE;
        repeat (2) @(posedge clk);
        chk("final_rsp_queue_empty", rsp_q.size(), 32'd0);
        chk("final_cmd_queue_empty", cmd_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported memory between the core's instruction-fetch port and data port, as driven by the fetch and memory pipeline stages. Accepts at most one request at a time, issues it downstream with a command/ready handshake, and routes the returned read data back to the originating requester. Sits between the pipeline top level and the memory model. When both requesters contend, the grant alternates round-robin so neither port starves.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data, write-data and write-mask width

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- inst_start  in  1  fetch request; address on inst_addr
- inst_ready  out  1  arbiter will accept inst_start this cycle
- inst_addr  in  ADDR_W  fetch address
- inst_data  out  DATA_W  fetched word; valid only while inst_valid
- inst_valid  out  1  one-cycle pulse, fetch complete
- d_cmd  in  3  data command: 0 NONE, 1 READ, 2 WRITE; 3–7 treated as NONE
- d_cmd_ready  out  1  arbiter will accept a non-NONE d_cmd this cycle
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wmask  in  DATA_W  write mask
- d_rdata  out  DATA_W  read word; valid only while d_rdata_valid
- d_rdata_valid  out  1  one-cycle pulse, data read complete
- mem_cmd  out  3  downstream command, same encoding
- mem_cmd_ready  in  1  memory accepts mem_cmd this cycle
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_wmask  out  DATA_W  downstream write mask
- mem_rdata  in  DATA_W  memory read data
- mem_rdata_valid  in  1  mem_rdata valid this cycle

## Operation
- States: IDLE, ISSUE, RD_WAIT.
- IDLE: inst_ready/d_cmd_ready are combinational from state and the round-robin pick; both 0 outside IDLE.
  - One request pending: that port's ready = 1.
  - Both pending: the port not granted last wins; only the winner's ready is 1.
- Acceptance (start/cmd & ready) latches addr, wdata, wmask, cmd (READ for inst), owner (INST/DATA) and updates last_grant; next state ISSUE.
- ISSUE: drive mem_cmd/mem_addr/mem_wdata/mem_wmask from the latches, held stable until mem_cmd_ready.
  - On mem_cmd_ready with READ: go to RD_WAIT; mem_cmd returns to NONE next cycle.
  - On mem_cmd_ready with WRITE: go to IDLE. Write completion is acceptance only; no valid pulse.
- RD_WAIT: on mem_rdata_valid, register mem_rdata into inst_data or d_rdata per owner, pulse the matching valid next cycle, and go to IDLE.
- mem_rdata_valid in IDLE or ISSUE is ignored.
- Data output registers hold their value after the valid pulse.

## Timing
- Reset values: state IDLE, mem_cmd NONE, mem_addr/mem_wdata/mem_wmask 0, inst_data/d_rdata 0, inst_valid/d_rdata_valid 0, last_grant DATA (the first tie goes to inst).
- Read latency, with accept at cycle N and zero-wait memory (mem_cmd_ready at N+1, mem_rdata_valid at N+2): valid pulse at N+3, ready high again at N+3.
- Write with accept at N and mem_cmd_ready at N+1: ready high again at N+2.
- A new request may be accepted in the same cycle the previous valid pulses.
- Requester must hold start/cmd/addr/wdata/wmask until its ready is seen; dropping the request earlier is legal and means no accept.
- Reset mid-operation: return to IDLE next cycle, no valid pulse, outstanding transaction abandoned. A late mem_rdata_valid is ignored per IDLE rule.
- Arbitration is evaluated only in IDLE; requests arriving while busy wait.

## Structure
- Package mem_pkg:
  - CMD_NONE/CMD_READ/CMD_WRITE 3-bit constants
  - state enum {IDLE, ISSUE, RD_WAIT}
  - owner enum {OWN_INST, OWN_DATA}
- Sub-module rr_arb2: 2-request round-robin picker (req[1:0], last_grant → grant[1:0]), purely combinational; last_grant register lives in mem_arbiter.

## Test plan
- After reset: inst_start, inst_addr=0x100; memory returns 0x00000013 one cycle after accept → inst_valid pulse at N+3 with inst_data=0x00000013, mem_addr=0x100, mem_cmd=READ for exactly 1 cycle.
- d_cmd=WRITE, d_addr=0x200, d_wdata=0xDEADBEEF, d_wmask=0xFFFFFFFF, mem_cmd_ready delayed 3 cycles → mem_* held stable 4 cycles, no valid pulse, d_cmd_ready high again the cycle after acceptance.
- inst and d_cmd=READ both pending continuously from reset → grants alternate inst, data, inst, data; each result returned on the correct port with its own data.
- Spurious mem_rdata_valid in IDLE with mem_rdata=0x55 → no valid pulse, outputs unchanged.
- Reset asserted in RD_WAIT, then mem_rdata_valid the next cycle → no valid pulse; subsequent inst fetch completes normally.
- d_cmd=5 with no inst request → d_cmd_ready=0, mem_cmd stays NONE.
